// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Centisecond stopwatch core. A prescaler divides clk down to the tick rate,
// and each prescaler wrap advances a four-digit BCD count SS.cc (00.00-59.99).
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count-tick rate in Hz; DIV = CLK_HZ/TICK_HZ must be >= 2
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   enable_count  1 = run, 0 = hold (prescaler and digits keep their value)
//   reset_count   1 = clear prescaler, digits, tick and overflow next edge
//   sec_tens      BCD seconds tens (0-5)
//   sec_ones      BCD seconds ones (0-9)
//   cs_tens       BCD centiseconds tens (0-9)
//   cs_ones       BCD centiseconds ones (0-9)
//   tick          one-cycle pulse on each counted centisecond
//   overflow      one-cycle pulse on the 59.99 -> 00.00 wrap
//   lap           (STOPWATCH_COUNTER_LAP_EN only) lap button, rising-edge
//   lap_active    (STOPWATCH_COUNTER_LAP_EN only) 1 while display is frozen
//
// Build option
//   STOPWATCH_COUNTER_LAP_EN  adds the lap-hold feature: a lap rising edge
//   freezes the displayed digits while the internal count keeps running;
//   the next rising edge returns to the live count.
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_count,
  input  logic       reset_count,
`ifdef STOPWATCH_COUNTER_LAP_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       tick,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Digit index 0 = cs_ones, 1 = cs_tens, 2 = sec_ones, 3 = sec_tens.
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    dig_q   [4];
  logic [3:0]    dig_d   [4];
  logic [3:0]    dig_inc [4];
  logic [3:0]    disp    [4];
  logic [3:0]    at_max;
  logic          all_max;
  logic          tick_q, tick_d;
  logic          ovf_q, ovf_d;

  // A digit at or above its top value rolls to 0 on carry-in. Using >= rather
  // than == means an out-of-range value can never propagate upward.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit_max
    localparam logic [3:0] MAXV = (gi == 3) ? 4'd5 : 4'd9;
    assign at_max[gi] = (dig_q[gi] >= MAXV);
  end

  assign all_max = &at_max;

  // Ripple the +1 centisecond through the digit chain.
  always_comb begin : digit_increment
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig_inc[i] = dig_q[i];
      if (carry) begin
        dig_inc[i] = at_max[i] ? 4'd0 : dig_q[i] + 4'd1;
      end
      carry = carry & at_max[i];
    end
  end

  // Next state: reset_count outranks enable_count. The digits advance on the
  // very edge the prescaler wraps, so tick and the new digits appear together.
  always_comb begin : count_next
    presc_d = presc_q;
    for (int i = 0; i < 4; i++) begin
      dig_d[i] = dig_q[i];
    end
    tick_d = 1'b0;
    ovf_d  = 1'b0;
    if (reset_count) begin
      presc_d = '0;
      for (int i = 0; i < 4; i++) begin
        dig_d[i] = 4'd0;
      end
    end else if (enable_count) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        for (int i = 0; i < 4; i++) begin
          dig_d[i] = dig_inc[i];
        end
        tick_d = 1'b1;
        ovf_d  = all_max;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin : count_reg
    if (reset) begin
      presc_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= 4'd0;
      end
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= dig_d[i];
      end
      tick_q <= tick_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef STOPWATCH_COUNTER_LAP_EN
  typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} lap_state_e;

  lap_state_e state_q, state_d;
  logic       lap_q;
  logic       lap_rise;
  logic       capture;
  logic [3:0] frz_q [4];

  assign lap_rise = lap & ~lap_q;

  // State register. lap_q follows the pin even through reset so that a lap
  // held high across reset is not mistaken for a fresh press.
  always_ff @(posedge clk) begin : lap_state_reg
    lap_q <= lap;
    if (reset) begin
      state_q <= LIVE;
      for (int i = 0; i < 4; i++) begin
        frz_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          frz_q[i] <= dig_q[i];
        end
      end
    end
  end

  // Next state: reset_count forces LIVE even when a lap edge coincides.
  always_comb begin : lap_state_next
    state_d = state_q;
    capture = 1'b0;
    if (reset_count) begin
      state_d = LIVE;
    end else if (lap_rise) begin
      if (state_q == LIVE) begin
        state_d = FROZEN;
        capture = 1'b1;
      end else begin
        state_d = LIVE;
      end
    end
  end

  always_comb begin : lap_outputs
    lap_active = (state_q == FROZEN);
    for (int i = 0; i < 4; i++) begin
      disp[i] = (state_q == FROZEN) ? frz_q[i] : dig_q[i];
    end
  end
`else
  always_comb begin : live_outputs
    for (int i = 0; i < 4; i++) begin
      disp[i] = dig_q[i];
    end
  end
`endif

  assign cs_ones  = disp[0];
  assign cs_tens  = disp[1];
  assign sec_ones = disp[2];
  assign sec_tens = disp[3];
  assign tick     = tick_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter with DIV = 10. The reference model keeps the
// count as a plain number of centiseconds (0..5999) and a cycle counter, and
// derives the expected BCD digits with division.
module tb_stopwatch_counter;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef STOPWATCH_COUNTER_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable_count, reset_count, lap_in;
  logic [3:0] sec_tens, sec_ones, cs_tens, cs_ones;
  logic       tick, overflow;
  logic       lap_active_o;

  stopwatch_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_count (enable_count),
    .reset_count  (reset_count),
`ifdef STOPWATCH_COUNTER_LAP_EN
    .lap          (lap_in),
    .lap_active   (lap_active_o),
`endif
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .cs_tens      (cs_tens),
    .cs_ones      (cs_ones),
    .tick         (tick),
    .overflow     (overflow)
  );

`ifndef STOPWATCH_COUNTER_LAP_EN
  assign lap_active_o = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model state
  int m_cs;       // centiseconds, 0..5999
  int m_presc;    // enabled cycles since last tick
  int m_latched;  // frozen display value
  bit m_frozen;
  bit m_lap_prev;
  bit m_tick, m_ovf;

  int checks = 0;
  int errors = 0;
  int tick_seen, ovf_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown_dut();
    return {sec_tens, sec_ones, cs_tens, cs_ones};
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs #1 later.
  task automatic cycle(input bit r, input bit rc, input bit en, input bit lp);
    bit          rise;
    int          shown;
    logic [15:0] exp_d;
    reset = r; reset_count = rc; enable_count = en; lap_in = lp;
    @(posedge clk);
    rise = lp && !m_lap_prev;
    if (r) begin
      m_cs = 0; m_presc = 0; m_tick = 0; m_ovf = 0; m_frozen = 0;
    end else begin
      if (LAP_EN) begin
        if (rc) m_frozen = 0;
        else if (rise) begin
          if (!m_frozen) begin
            m_frozen  = 1;
            m_latched = m_cs;
          end else begin
            m_frozen = 0;
          end
        end
      end
      m_tick = 0;
      m_ovf  = 0;
      if (rc) begin
        m_cs = 0; m_presc = 0;
      end else if (en) begin
        m_presc++;
        if (m_presc == DIV) begin
          m_presc = 0;
          m_cs    = (m_cs + 1) % 6000;
          m_tick  = 1;
          m_ovf   = (m_cs == 0);
        end
      end
    end
    m_lap_prev = lp;
    #1;
    shown = m_frozen ? m_latched : m_cs;
    exp_d = to_bcd(shown);
    check("sec_tens", 32'(sec_tens), 32'(exp_d[15:12]));
    check("sec_ones", 32'(sec_ones), 32'(exp_d[11:8]));
    check("cs_tens",  32'(cs_tens),  32'(exp_d[7:4]));
    check("cs_ones",  32'(cs_ones),  32'(exp_d[3:0]));
    check("tick",     32'(tick),     32'(m_tick));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef STOPWATCH_COUNTER_LAP_EN
    check("lap_active", 32'(lap_active_o), 32'(m_frozen));
`endif
    if (tick === 1'b1) tick_seen++;
    if (overflow === 1'b1) ovf_seen++;
  endtask

  initial begin
    int first;
    bit r, rc, en, lp;
    m_cs = 0; m_presc = 0; m_latched = 0; m_frozen = 0; m_lap_prev = 0;
    m_tick = 0; m_ovf = 0; tick_seen = 0; ovf_seen = 0;
    reset = 1'b1; reset_count = 1'b0; enable_count = 1'b0; lap_in = 1'b0;

    // Reset, then 10 enabled cycles give exactly one tick and 00.01
    cycle(1, 0, 0, 0);
    check("reset_digits", 32'(shown_dut()), 32'h0000);
    check("reset_tick", 32'({tick, overflow}), 32'h0);
    tick_seen = 0;
    repeat (10) cycle(0, 0, 1, 0);
    check("first_tick_count", tick_seen, 1);
    check("first_tick_disp", 32'(shown_dut()), 32'h0001);
    $display("txn run10: display %h ticks %0d", shown_dut(), tick_seen);

    // Hold keeps the partial prescaler count
    cycle(1, 0, 0, 0);
    tick_seen = 0;
    repeat (5)  cycle(0, 0, 1, 0);
    repeat (20) cycle(0, 0, 0, 0);
    repeat (5)  cycle(0, 0, 1, 0);
    check("hold_tick_count", tick_seen, 1);
    check("hold_disp", 32'(shown_dut()), 32'h0001);
    $display("txn hold: display %h ticks %0d", shown_dut(), tick_seen);

    // Run to 59.99, then wrap
    cycle(1, 0, 0, 0);
    repeat (5999 * DIV) cycle(0, 0, 1, 0);
    check("pre_wrap_disp", 32'(shown_dut()), 32'h5999);
    ovf_seen = 0; tick_seen = 0;
    repeat (DIV) cycle(0, 0, 1, 0);
    check("wrap_disp", 32'(shown_dut()), 32'h0000);
    check("wrap_ovf_count", ovf_seen, 1);
    check("wrap_tick_count", tick_seen, 1);
    $display("txn wrap: display %h overflow pulses %0d", shown_dut(), ovf_seen);

    // Reset at 07.77 with prescaler 6 discards the partial tick
    repeat (777 * DIV + 6) cycle(0, 0, 1, 0);
    check("pre_reset_disp", 32'(shown_dut()), 32'h0777);
    cycle(1, 0, 1, 0);
    check("mid_reset_disp", 32'(shown_dut()), 32'h0000);
    first = -1;
    for (int i = 1; i <= 2 * DIV; i++) begin
      cycle(0, 0, 1, 0);
      if (tick === 1'b1 && first < 0) first = i;
    end
    check("reset_first_tick", first, DIV);
    $display("txn reset@07.77: first tick after %0d cycles", first);

    // reset_count with enable_count=1 at 12.34
    cycle(1, 0, 0, 0);
    repeat (1234 * DIV) cycle(0, 0, 1, 0);
    check("pre_clear_disp", 32'(shown_dut()), 32'h1234);
    cycle(0, 1, 1, 0);
    check("clear_disp", 32'(shown_dut()), 32'h0000);
    first = -1;
    for (int i = 1; i <= 2 * DIV; i++) begin
      cycle(0, 0, 1, 0);
      if (tick === 1'b1 && first < 0) first = i;
    end
    check("clear_first_tick", first, DIV);
    $display("txn reset_count@12.34: first tick after %0d cycles", first);

`ifdef STOPWATCH_COUNTER_LAP_EN
    // Lap freeze at 03.21, run 50 ticks, release shows 03.71
    cycle(1, 0, 0, 0);
    repeat (321 * DIV + 3) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    repeat (50 * DIV - 2) cycle(0, 0, 1, 0);
    check("lap_frozen_disp", 32'(shown_dut()), 32'h0321);
    check("lap_frozen_active", 32'(lap_active_o), 32'h1);
    cycle(0, 0, 1, 1);
    check("lap_release_disp", 32'(shown_dut()), 32'h0371);
    check("lap_release_active", 32'(lap_active_o), 32'h0);
    cycle(0, 0, 1, 0);
    $display("txn lap: display %h", shown_dut());
`endif

    // Randomized mix of run/hold/clear/reset/lap against the model
    repeat (3000) begin
      r  = ($urandom_range(0, 299) == 0);
      rc = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 3) != 0);
      lp = ($urandom_range(0, 7) == 0);
      cycle(r, rc, en, lp);
    end
    $display("txn random: final display %h", shown_dut());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
